// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_pkg;

  typedef enum logic [2:0] {
    StFetch,
    StWait,
    StHold,
    StDrain,
    StHalt
  } fetch_state_e;

  localparam logic [31:0] Nop            = 32'h0000_0013;
  localparam logic [31:0] ResetPcDefault = 32'h0000_0000;

endpackage

// File: rtl/fetch_hold_buf.sv
// Single-entry buffer that parks a fetched word while the decode stage is stalled.
module fetch_hold_buf (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        clear,
  input  logic [31:0] din,
  output logic [31:0] dout,
  output logic        valid
);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dout <= 32'h0000_0000;
    end else if (load) begin
      dout <= din;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: one outstanding imem request, stall hold buffer, redirect drain.
// Define FETCH_MISALIGN_TRAP_EN to trap misaligned redirect targets into a sticky HALT.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = ResetPcDefault
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr_out,
  output logic [31:0] pc_out,
  output logic        fetch_fault
);

  fetch_state_e state_q;
  logic [31:0]  pc_q;
  logic [31:0]  target;
  logic         misalign;
  logic         buf_load;
  logic         buf_clear;
  logic         buf_valid;
  logic [31:0]  buf_data;

`ifdef FETCH_MISALIGN_TRAP_EN
  assign target   = redirect_pc;
  assign misalign = |redirect_pc[1:0];
`else
  logic unused_lsb;
  assign unused_lsb = ^redirect_pc[1:0];
  assign target     = {redirect_pc[31:2], 2'b00};
  assign misalign   = 1'b0;
`endif

  assign imem_req  = (state_q == StFetch) && !rst;
  assign imem_addr = pc_q;

  assign buf_load  = !rst && (state_q == StWait) && !redirect_valid && imem_rvalid && stall;
  assign buf_clear = !rst && (state_q == StHold) && (redirect_valid || !stall);

  fetch_hold_buf u_hold_buf (
    .clk   (clk),
    .rst   (rst),
    .load  (buf_load),
    .clear (buf_clear),
    .din   (imem_rdata),
    .dout  (buf_data),
    .valid (buf_valid)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      // A request still in flight when reset hits must have its response swallowed.
      if (state_q == StWait || state_q == StDrain) begin
        if (imem_rvalid) begin
          state_q <= StFetch;
        end else begin
          state_q <= StDrain;
        end
      end else begin
        state_q <= StFetch;
      end
      pc_q        <= RESET_PC;
      instr_valid <= 1'b0;
      instr_out   <= Nop;
      pc_out      <= RESET_PC;
      fetch_fault <= 1'b0;
    end else if (state_q == StHalt) begin
      instr_valid <= 1'b0;
      instr_out   <= Nop;
    end else if (redirect_valid) begin
      instr_valid <= 1'b0;
      instr_out   <= Nop;
      if (misalign) begin
        fetch_fault <= 1'b1;
        state_q     <= StHalt;
      end else begin
        pc_q <= target;
        case (state_q)
          StFetch: state_q <= imem_ready ? StDrain : StFetch;
          StWait:  state_q <= imem_rvalid ? StFetch : StDrain;
          // A response landing with the redirect is the one being drained.
          StDrain: state_q <= imem_rvalid ? StFetch : StDrain;
          default: state_q <= StFetch;
        endcase
      end
    end else begin
      if (!stall) begin
        instr_valid <= 1'b0;
        instr_out   <= Nop;
      end
      case (state_q)
        StFetch: begin
          if (imem_ready) state_q <= StWait;
        end
        StWait: begin
          if (imem_rvalid) begin
            pc_q <= pc_q + 32'd4;
            if (!stall) begin
              instr_valid <= 1'b1;
              instr_out   <= imem_rdata;
              pc_out      <= pc_q;
              state_q     <= StFetch;
            end else begin
              state_q <= StHold;
            end
          end
        end
        StHold: begin
          if (!stall) begin
            if (buf_valid) begin
              instr_valid <= 1'b1;
              instr_out   <= buf_data;
              pc_out      <= pc_q - 32'd4;
            end
            state_q <= StFetch;
          end
        end
        StDrain: begin
          if (imem_rvalid) state_q <= StFetch;
        end
        default: state_q <= StFetch;
      endcase
    end
  end

endmodule
